// File: rtl/posit_pkg.sv
// Shared posit definitions: word format constants and special-value helpers.
package posit_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 4;

    typedef logic [POSIT_N-1:0] posit32_t;

    localparam posit32_t POSIT_NAR  = 32'h8000_0000;
    localparam posit32_t POSIT_ZERO = 32'h0000_0000;

    function automatic logic is_nar(input posit32_t p);
        return p == POSIT_NAR;
    endfunction

    function automatic logic is_zero(input posit32_t p);
        return p == POSIT_ZERO;
    endfunction

endpackage

// File: rtl/Posit_Multiplier.sv
// Combinational posit multiplier: decode both operands, multiply the mantissas,
// re-encode with round-to-nearest-even, saturating at maxpos/minpos.
module Posit_Multiplier #(
    parameter int N  = 32,
    parameter int ES = 4
) (
    input  logic [N-1:0] IN1,
    input  logic [N-1:0] IN2,
    output logic [N-1:0] OUT
);
    localparam int FW   = N - 1 - ES;
    localparam int MW   = FW + 1;
    localparam int PW   = 2 * MW;
    localparam int SW   = $clog2(N) + ES + 3;
    localparam int RW   = $clog2(N) + 1;
    localparam int W    = 3 * N;
    localparam int PADW = W - 1 - ES - PW;
    localparam logic signed [SW-1:0] SMAX = SW'((N - 2) << ES);
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef struct packed {
        logic                 sgn;
        logic signed [SW-1:0] scale;
        logic [MW-1:0]        mant;
    } dec_t;

    function automatic dec_t decode(input logic [N-1:0] x);
        dec_t                 d;
        logic [N-1:0]         a;
        logic [N-2:0]         rem;
        logic [RW-1:0]        run;
        logic                 stop;
        logic signed [SW-1:0] k;
        a    = x[N-1] ? -x : x;
        run  = '0;
        stop = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && a[i] == a[N-2]) run = run + RW'(1);
            else stop = 1'b1;
        end
        // Drop regime run and its terminator; exponent bits falling off the end read as zero.
        rem     = (N-1)'(a << (run + RW'(1)));
        k       = a[N-2] ? SW'(run) - SW'(1) : -SW'(run);
        d.sgn   = x[N-1];
        d.scale = (k <<< ES) + SW'(rem[N-2 -: ES]);
        d.mant  = {1'b1, rem[FW-1:0]};
        return d;
    endfunction

    dec_t                 da, db;
    logic [PW-1:0]        p;
    logic signed [SW-1:0] s, k;
    logic [ES-1:0]        e;
    logic [PW-2:0]        f;
    logic [W-1:0]         start, vs;
    logic signed [W-1:0]  ss;
    logic [RW-1:0]        sh;
    logic [N-2:0]         m;
    logic                 up;

    always_comb begin
        da    = decode(IN1);
        db    = decode(IN2);
        p     = PW'({{MW{1'b0}}, da.mant} * {{MW{1'b0}}, db.mant});
        s     = da.scale + db.scale + SW'(p[PW-1]);
        f     = p[PW-1] ? p[PW-2:0] : {p[PW-3:0], 1'b0};
        k     = s >>> ES;
        e     = s[ES-1:0];
        // Regime seed "10" (k>=0) is sign-extended into k+1 ones; "01" (k<0) shifts into -k zeros.
        start = {~k[SW-1], k[SW-1], e, f, {PADW{1'b0}}};
        ss    = start;
        sh    = k[SW-1] ? RW'(-k - SW'(1)) : RW'(k);
        if (k[SW-1]) vs = start >> sh;
        else         vs = ss >>> sh;
        m     = vs[W-1 -: N-1];
        up    = vs[W-N] & ((|vs[W-N-1:0]) | m[0]);
        m     = m + (N-1)'(up);
        if (s >= SMAX)      m = '1;
        else if (s < -SMAX) m = (N-1)'(1);
        OUT = (da.sgn ^ db.sgn) ? -{1'b0, m} : {1'b0, m};
        if (IN1 == NAR || IN2 == NAR)      OUT = NAR;
        else if (IN1 == '0 || IN2 == '0)   OUT = '0;
    end

endmodule

// File: rtl/posit_mul_pipe.sv
// Elastic two-stage valid/ready wrapper around Posit_Multiplier with tag sideband.
// Define POSIT_MUL_SPECIAL_BYPASS_EN to resolve NaR/zero operands outside the core and drive the flags.
module posit_mul_pipe
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic [TW-1:0] out_tag,
    output logic          out_nar,
    output logic          out_zero,
    output logic          busy
);
    logic          v1, v2, nar2, zero2, adv1, adv2;
    logic [N-1:0]  a1, b1, r2, mul_out, r_n;
    logic [TW-1:0] t1, t2;
    logic          nar_n, zero_n;

    assign adv2     = !v2 | out_ready;
    assign adv1     = !v1 | adv2;
    assign in_ready = adv1 & !rst;

    Posit_Multiplier #(.N(N), .ES(ES)) u_mul (
        .IN1 (a1),
        .IN2 (b1),
        .OUT (mul_out)
    );

    always_comb begin
        r_n    = mul_out;
        nar_n  = 1'b0;
        zero_n = 1'b0;
`ifdef POSIT_MUL_SPECIAL_BYPASS_EN
        if (is_nar(a1) || is_nar(b1)) begin
            r_n   = POSIT_NAR;
            nar_n = 1'b1;
        end else if (is_zero(a1) || is_zero(b1)) begin
            r_n    = POSIT_ZERO;
            zero_n = 1'b1;
        end else begin
            nar_n  = is_nar(mul_out);
            zero_n = is_zero(mul_out);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            r2    <= '0;
            t2    <= '0;
            nar2  <= 1'b0;
            zero2 <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    a1 <= in_a;
                    b1 <= in_b;
                    t1 <= in_tag;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    r2    <= r_n;
                    t2    <= t1;
                    nar2  <= nar_n;
                    zero2 <= zero_n;
                end
            end
        end
    end

    assign out_valid  = v2;
    assign out_result = r2;
    assign out_tag    = t2;
    assign out_nar    = nar2;
    assign out_zero   = zero2;
    assign busy       = v1 | v2;

endmodule

// File: tb/tb_posit_mul_pipe.sv
// Directed bench for posit_mul_pipe: hand-computed products checked through a FIFO scoreboard.
module tb_posit_mul_pipe;
`ifdef POSIT_MUL_SPECIAL_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_nar, out_zero, busy;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  in_tag, out_tag;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        nar;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    exp_t nxt;
    int   total = 0, bad = 0, rx = 0, rx0, idx;
    logic acc;

    logic [31:0] va [4] = '{32'h4200_0000, 32'h4100_0000, 32'h4400_0000, 32'hC000_0000};
    logic [31:0] vb [4] = '{32'h4200_0000, 32'h4100_0000, 32'h4200_0000, 32'h4200_0000};
    logic [31:0] vr [4] = '{32'h4400_0000, 32'h4240_0000, 32'h4600_0000, 32'hBE00_0000};

    posit_mul_pipe #(.N(32), .ES(4), .TW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_nar    (out_nar),
        .out_zero   (out_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Score the handshakes about to happen at the next edge, then advance one cycle.
    task automatic step();
        exp_t e;
        if (rst) sb.delete();
        else begin
            if (out_valid === 1'b1 && out_ready) begin
                chk("pending", {31'b0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("res", out_result, e.res);
                    chk("tag", {28'b0, out_tag}, {28'b0, e.tag});
                    chk("nar", {31'b0, out_nar}, {31'b0, e.nar});
                    chk("zero", {31'b0, out_zero}, {31'b0, e.zero});
                end
                rx++;
            end
            if (in_valid && in_ready === 1'b1) sb.push_back(nxt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                         input logic [31:0] r, input logic nar, input logic zero);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        nxt      = '{res: r, tag: t, nar: nar, zero: zero};
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && (sb.size() != 0 || busy); i++) step();
        chk("drain", 32'(sb.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b1; nxt = '0;
        offer(32'h4200_0000, 32'h4200_0000, 4'd9, 32'h4400_0000, 1'b0, 1'b0);
        repeat (3) begin
            step();
            chk("rst_ctl", {27'b0, in_ready, out_valid, busy, out_nar, out_zero}, 0);
            chk("rst_res", out_result, 0);
            chk("rst_tag", {28'b0, out_tag}, 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rdy_release", {31'b0, in_ready}, 1);

        // single op, 2 x 2 = 4
        offer(32'h4200_0000, 32'h4200_0000, 4'd5, 32'h4400_0000, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("lat_k", {30'b0, out_valid, busy}, 32'b01);
        step();
        chk("lat_k1", {31'b0, out_valid}, 1);
        chk("single_res", out_result, 32'h4400_0000);
        chk("single_tag", {28'b0, out_tag}, 5);
        step();
        chk("single_done", {30'b0, out_valid, busy}, 0);

        // streaming 1 x 1
        rx0 = rx;
        for (int i = 0; i < 8; i++) begin
            offer(32'h4000_0000, 32'h4000_0000, 4'(i), 32'h4000_0000, 1'b0, 1'b0);
            chk("stream_rdy", {31'b0, in_ready}, 1);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("stream_cnt", 32'(rx - rx0), 8);

        // backpressure
        rx0 = rx; idx = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 2 && c < 5);
            if (idx < 4) offer(va[idx], vb[idx], 4'(8 + idx), vr[idx], 1'b0, 1'b0);
            else in_valid = 1'b0;
            #1;
            if (c >= 2 && c < 5) begin
                chk("bp_rdy", {31'b0, in_ready}, 0);
                chk("bp_vld", {31'b0, out_valid}, 1);
                chk("bp_hold", out_result, vr[0]);
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        drain();
        chk("bp_all_in", 32'(idx), 4);
        chk("bp_cnt", 32'(rx - rx0), 4);

        // special values and negative regimes
        offer(32'h8000_0000, 32'h4000_0000, 4'd1, 32'h8000_0000, BYP, 1'b0);
        step();
        offer(32'h0000_0000, 32'h4200_0000, 4'd2, 32'h0000_0000, 1'b0, BYP);
        step();
        offer(32'h3E00_0000, 32'h4200_0000, 4'd3, 32'h4000_0000, 1'b0, 1'b0);
        step();
        offer(32'h3E00_0000, 32'h3E00_0000, 4'd4, 32'h3C00_0000, 1'b0, 1'b0);
        step();
        drain();

        // reset with both stages full
        out_ready = 1'b0;
        offer(32'h4200_0000, 32'h4200_0000, 4'd6, 32'h4400_0000, 1'b0, 1'b0);
        step();
        offer(32'h4400_0000, 32'h4200_0000, 4'd7, 32'h4600_0000, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("full_ctl", {30'b0, out_valid, in_ready}, 32'b10);
        rst = 1'b1;
        step();
        chk("midrst", {30'b0, out_valid, busy}, 0);
        rst = 1'b0; out_ready = 1'b1;
        rx0 = rx;
        repeat (4) step();
        chk("no_stale", 32'(rx - rx0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
